sti_rx_deser: RTL and testbench
===============================

// Module: sti_rx_deser
// PURPOSE
//  Downstream stage of the serial transmitter. Consumes the so_data/so_valid bit stream, rebuilds each
//  serial word (8/16/24/32 bits, MSB- or LSB-first), checks its length and queues it in a small FIFO.
//  The queue has a valid/ready output toward the checker or memory writer.
//  Also reports end-of-frame completion and sticky overflow.
// PARAMETERS
//  FIFO_DEPTH  4   output queue entries; must be a power of 2, >=2
// PORTS
//  clk         in   1   clock, all logic posedge
//  reset       in   1   synchronous, active-high
//  cfg_length  in   2   expected word length: 0=8, 1=16, 2=24, 3=32 bits
//  cfg_msb     in   1   1 = stream is MSB-first, 0 = LSB-first
//  si_data     in   1   serial bit, qualified by si_valid
//  si_valid    in   1   high for each consecutive bit of one word; a low cycle terminates the word
//  frame_end   in   1   one-cycle pulse: no further words in this frame
//  out_ready   in   1   consumer accepts head entry
//  out_valid   out  1   FIFO non-empty
//  out_data    out  32  assembled word, right-justified, upper bits zero
//  out_len     out  2   cfg_length captured for this word
//  out_err     out  1   bit count of this word != 8*(out_len+1)
//  frame_done  out  1   one-cycle pulse, see below
//  overflow    out  1   sticky: a completed word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_len=0, out_err=0, frame_done=0, overflow=0. FIFO emptied,
//   partial word discarded, state IDLE. Reset mid-word discards the word; it is never pushed.
//  FSM IDLE -> SHIFT on si_valid=1: clear shreg and bit count; capture cfg_length and cfg_msb;
//   absorb the first bit in the same edge. Config is held for the whole word.
//  SHIFT: each si_valid=1 cycle absorbs one bit and increments cnt (6 bits, saturates at 33).
//   MSB-first: shreg <= {shreg[30:0], si_data}.
//   LSB-first: shreg[cnt] <= si_data for cnt<32; bits past 32 are dropped.
//  SHIFT -> IDLE on the first si_valid=0 cycle. At that edge push {shreg, len, err} into the FIFO:
//   err = (cnt != 8*(len+1)).
//   For MSB-first with cnt>32, data = last 32 bits received.
//   Back-to-back words need >=1 idle cycle; there is no zero-gap word boundary.
//  Latency: last bit at cycle t, si_valid low at t+1, push at edge ending t+1, out_valid=1 in t+2
//   when the FIFO was empty.
//  FIFO: out_* shows the head entry, registered. Pop when out_valid && out_ready.
//   Push when full: if a pop happens in the same cycle the push is accepted; otherwise the word is
//   dropped and overflow <= 1 until reset.
//   Push when empty: out_valid is not combinationally driven from the push.
//   Count-based full/empty; pointers wrap mod FIFO_DEPTH.
//  Frame: frame_end sets an internal pend flag; a second frame_end while pending is ignored.
//   frame_done pulses for 1 cycle on the first cycle where pend=1, state=IDLE, si_valid=0 and the
//   FIFO is empty (after the final pop); then pend is cleared.
//   frame_end during SHIFT waits for that word to be pushed and drained.
//   frame_end with nothing outstanding gives frame_done 1 cycle later.
// STRUCTURE
//  Shared package sti_pkg: length codes LEN_8/16/24/32, function len_bits(code)=8*(code+1),
//   FIFO entry struct {data[31:0], len[1:0], err}.
//  One sub-module: sti_sync_fifo (parameterised width/depth, registered head, count-based flags).
//  Top level contains the IDLE/SHIFT FSM, assembler, length check and frame tracker.
// TESTING
//  1. len=0, msb=1, bits 1,0,1,0,0,1,0,1 then gap -> out_data=32'h0000_00A5, out_err=0,
//     out_valid rises 2 cycles after last bit.
//  2. len=1, msb=0, send 16'h1234 LSB first -> out_data=32'h0000_1234, out_len=1, out_err=0.
//  3. len=3, msb=1, send 32'hDEADBEEF; then len=2 but only 16 bits of 16'hBEEF ->
//     first pop 32'hDEADBEEF err=0; second pop 32'h0000_BEEF err=1.
//  4. out_ready=0, push FIFO_DEPTH+1 8-bit words 8'h01.. -> overflow=1;
//     pops return 01..04 in order, 05 is lost.
//     Repeat at full with out_ready=1 on the push cycle -> no overflow.
//  5. frame_end mid-word with out_ready=1 -> frame_done exactly once, 1 cycle after the last pop;
//     frame_end alone in IDLE -> frame_done next cycle.
//  6. reset asserted after 5 bits of a word -> all outputs at reset values, no entry pushed,
//     next word assembles correctly.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared definitions for the serial-transmitter receive path: length codes,
// the FIFO entry layout and the FSM state encoding.
package sti_pkg;

    localparam logic [1:0] LEN_8  = 2'd0;
    localparam logic [1:0] LEN_16 = 2'd1;
    localparam logic [1:0] LEN_24 = 2'd2;
    localparam logic [1:0] LEN_32 = 2'd3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit counter saturates one past the longest legal word so overlong words stay flagged.
    localparam logic [5:0] CNT_SAT = 6'd33;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  len;
        logic        err;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic [5:0] len_bits(input logic [1:0] code);
        return {1'b0, code, 3'b000} + 6'd8;
    endfunction

endpackage

// File: rtl/sti_sync_fifo.sv
// Synchronous FIFO with count-based flags; the head entry is presented from
// storage registers and reads as zero while empty.
module sti_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             drop_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full, empty, pop_ok, push_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_i && !empty;
    // A push into a full queue still lands if the head leaves on the same edge.
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && !push_ok;

    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sti_rx_deser.sv
// Serial word receiver: rebuilds each si_valid burst into a word, checks its
// length against the captured config, queues it and tracks frame completion.
module sti_rx_deser
    import sti_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic        frame_end,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [1:0]  out_len,
    output logic        out_err,
    output logic        frame_done,
    output logic        overflow,
    output logic [0:0]  dbg_state_o
);

    logic [0:0]  state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  len_q, len_d;
    logic        msb_q, msb_d;
    logic        pend_q, pend_d;
    logic        ovf_q, ovf_d;

    logic        push;
    logic        fifo_valid;
    logic        fifo_drop;
    fifo_entry_t push_entry;
    fifo_entry_t head;

    // Handshake: an entry transfers on any clk edge where out_valid && out_ready;
    // out_valid never drops without a transfer, and out_* stay stable while stalled.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        msb_d   = msb_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (si_valid) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 6'd1;
                    len_d   = cfg_length;
                    msb_d   = cfg_msb;
                    shreg_d = {31'b0, si_data};
                end
            end
            ST_SHIFT: begin
                if (si_valid) begin
                    if (msb_q) begin
                        shreg_d = {shreg_q[30:0], si_data};
                    end else if (!cnt_q[5]) begin
                        shreg_d[cnt_q[4:0]] = si_data;
                    end
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 6'd1;
                end else begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign push_entry.data = shreg_q;
    assign push_entry.len  = len_q;
    assign push_entry.err  = (cnt_q != len_bits(len_q));

    // Frame completes only once nothing is in flight and the queue has fully drained.
    assign frame_done = pend_q && (state_q == ST_IDLE) && !si_valid && !fifo_valid;

    always_comb begin
        pend_d = pend_q;
        if (frame_done)     pend_d = 1'b0;
        else if (frame_end) pend_d = 1'b1;
        ovf_d = ovf_q | fifo_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_8;
            msb_q   <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            msb_q   <= msb_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    sti_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (out_ready),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .drop_o      (fifo_drop)
    );

    assign out_valid   = fifo_valid;
    assign out_data    = head.data;
    assign out_len     = head.len;
    assign out_err     = head.err;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sti_rx_deser.sv
// Directed bench for sti_rx_deser: expected entries are queued as words are sent
// and a negedge monitor compares every popped head entry against them.
module tb_sti_rx_deser;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        si_data;
    logic        si_valid;
    logic        frame_end;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_len;
    logic        out_err;
    logic        frame_done;
    logic        overflow;
    logic [0:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fd_cnt  = 0;
    int fd_cyc  = -1;
    int pop_cyc = -1;
    logic [34:0] exp_q[$];

    sti_rx_deser #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_length  (cfg_length),
        .cfg_msb     (cfg_msb),
        .si_data     (si_data),
        .si_valid    (si_valid),
        .frame_end   (frame_end),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_len     (out_len),
        .out_err     (out_err),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted head entry must match the oldest expectation.
    always @(negedge clk) begin
        logic [34:0] e;
        if (!reset && frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (!reset && out_valid && out_ready) begin
            pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got data=%h len=%0d err=%0d required no entry",
                         out_data, out_len, out_err);
            end else begin
                e = exp_q.pop_front();
                check("pop_entry", {out_data, out_len, out_err}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [1:0] len, input logic err);
        exp_q.push_back({d, len, err});
    endtask

    task automatic send_word(input logic [1:0] len, input logic msb, input int nbits,
                             input logic [31:0] data, input bit chk_lat, input int gap_rdy);
        cfg_length = len;
        cfg_msb    = msb;
        for (int i = 0; i < nbits; i++) begin
            si_valid = 1'b1;
            si_data  = msb ? data[nbits-1-i] : data[i];
            tick();
        end
        si_valid = 1'b0;
        si_data  = 1'b0;
        if (chk_lat) check("lat_gap_valid", {34'b0, out_valid}, 35'd0);
        if (gap_rdy >= 0) out_ready = (gap_rdy != 0);
        tick();
        if (chk_lat) check("lat_valid", {34'b0, out_valid}, 35'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && (exp_q.size() != 0 || out_valid); k++) tick();
        check("drain_out_valid", {34'b0, out_valid}, 35'd0);
        check("drain_queue", 35'(exp_q.size()), 35'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        si_valid  = 1'b0;
        si_data   = 1'b0;
        frame_end = 1'b0;
        tick();
        exp_q.delete();
        check("rst_out_valid",  {34'b0, out_valid}, 35'd0);
        check("rst_out_data",   {3'b0, out_data}, 35'd0);
        check("rst_out_len",    {33'b0, out_len}, 35'd0);
        check("rst_out_err",    {34'b0, out_err}, 35'd0);
        check("rst_frame_done", {34'b0, frame_done}, 35'd0);
        check("rst_overflow",   {34'b0, overflow}, 35'd0);
        check("rst_state",      {34'b0, dbg_state}, 35'd0);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int fd0;
        reset      = 1'b1;
        cfg_length = 2'd0;
        cfg_msb    = 1'b0;
        si_data    = 1'b0;
        si_valid   = 1'b0;
        frame_end  = 1'b0;
        out_ready  = 1'b0;
        tick();
        do_reset();

        // 8-bit MSB-first word with latency check
        out_ready = 1'b0;
        expect_word(32'h0000_00A5, 2'd0, 1'b0);
        send_word(2'd0, 1'b1, 8, 32'hA5, 1'b1, -1);
        drain();

        // 16-bit LSB-first
        expect_word(32'h0000_1234, 2'd1, 1'b0);
        send_word(2'd1, 1'b0, 16, 32'h1234, 1'b1, -1);
        drain();

        // full 32-bit word followed by a short 24-bit word
        expect_word(32'hDEAD_BEEF, 2'd3, 1'b0);
        expect_word(32'h0000_BEEF, 2'd2, 1'b1);
        send_word(2'd3, 1'b1, 32, 32'hDEADBEEF, 1'b0, -1);
        send_word(2'd2, 1'b1, 16, 32'hBEEF, 1'b0, -1);
        drain();

        // overflow: fifth word dropped while stalled
        out_ready = 1'b0;
        for (int w = 1; w <= DEPTH + 1; w++) begin
            if (w <= DEPTH) expect_word(32'(w), 2'd0, 1'b0);
            send_word(2'd0, 1'b1, 8, 32'(w), 1'b0, -1);
        end
        check("ovf_set", {34'b0, overflow}, 35'd1);
        drain();
        check("ovf_sticky", {34'b0, overflow}, 35'd1);

        // full queue with a pop on the push edge: nothing lost
        do_reset();
        out_ready = 1'b0;
        for (int w = 1; w <= DEPTH; w++) begin
            expect_word(32'(w), 2'd0, 1'b0);
            send_word(2'd0, 1'b1, 8, 32'(w), 1'b0, -1);
        end
        expect_word(32'h05, 2'd0, 1'b0);
        send_word(2'd0, 1'b1, 8, 32'h05, 1'b0, 1);
        check("ovf_pop_push", {34'b0, overflow}, 35'd0);
        drain();
        check("ovf_after_drain", {34'b0, overflow}, 35'd0);

        // frame_end mid-word (twice) -> one frame_done right after the last pop
        fd0 = fd_cnt;
        out_ready = 1'b1;
        cfg_length = 2'd0;
        cfg_msb    = 1'b1;
        expect_word(32'h5A, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'h5A;
            si_valid  = 1'b1;
            si_data   = b[7-i];
            frame_end = (i == 2 || i == 5);
            tick();
        end
        si_valid  = 1'b0;
        frame_end = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("fd_count_mid", 35'(fd_cnt - fd0), 35'd1);
        check("fd_after_pop", 35'(fd_cyc - pop_cyc), 35'd1);
        check("fd_queue", 35'(exp_q.size()), 35'd0);

        // frame_end alone in IDLE
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("fd_idle_next", {34'b0, frame_done}, 35'd1);
        tick();
        check("fd_idle_pulse", {34'b0, frame_done}, 35'd0);

        // reset mid-word with an entry queued
        out_ready = 1'b0;
        expect_word(32'h11, 2'd0, 1'b0);
        send_word(2'd0, 1'b1, 8, 32'h11, 1'b0, -1);
        check("pre_rst_valid", {34'b0, out_valid}, 35'd1);
        cfg_msb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            si_valid = 1'b1;
            si_data  = i[0];
            tick();
        end
        do_reset();
        for (int k = 0; k < 3; k++) tick();
        check("post_rst_no_push", {34'b0, out_valid}, 35'd0);
        out_ready = 1'b1;
        expect_word(32'h3C, 2'd0, 1'b0);
        send_word(2'd0, 1'b0, 8, 32'h3C, 1'b0, -1);
        drain();

        check("final_queue", 35'(exp_q.size()), 35'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
